prbs_checker_8bit: RTL and testbench
====================================

PRBS_CHECKER_8BIT -- requirements
Module: prbs_checker_8bit

Interface
REQ-001 Parameter: LOSS_THRESH, default 4, number of consecutive mismatches in LOCKED that forces resynchronisation (range 1..15).
REQ-002 Parameter: CNT_W, default 16, width of the error counter.
REQ-003 Port: clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 Port: reset  input  1  asynchronous, active-high reset.
REQ-005 Port: tap  input  8  feedback polynomial mask, same convention as the team's 8-bit LFSR generator: next bit = XOR-reduce(state & tap).
REQ-006 Port: din_valid  input  1  qualifies din; the checker does nothing in cycles where it is low.
REQ-007 Port: din  input  1  received serial bit, equal to the bit the generator shifts into its LSB each step.
REQ-008 Port: clr_cnt  input  1  synchronous clear of err_cnt.
REQ-009 Port: locked  output  1  high while in LOCKED.
REQ-010 Port: bit_err  output  1  one-cycle pulse per mismatching bit in LOCKED.
REQ-011 Port: err_cnt  output  CNT_W  saturating count of bit_err pulses.
REQ-012 Port: state_out  output  8  current checker shift register.

Function
REQ-013 The checker SHALL hold an 8-bit shift register sr and a registered copy tap_q; predicted bit p = XOR-reduce(sr & tap_q).
REQ-014 The FSM SHALL have three states: SEED, VERIFY and LOCKED.
REQ-015 SEED: on each valid bit, sr <= {sr[6:0], din}; no comparison; after 8 valid bits, go to VERIFY, unless the new sr is 8'h00, in which case restart the 8-bit fill in SEED.
REQ-016 VERIFY: on each valid bit, compare din with p and shift in din; any mismatch -> SEED with fill count 0; 8 consecutive matches -> LOCKED.
REQ-017 LOCKED: on each valid bit, shift in p (flywheel, not din); on a mismatch, pulse bit_err and increment a consecutive-error counter; on a match, clear it.
REQ-018 When the consecutive-error counter reaches LOSS_THRESH, the FSM SHALL go to SEED on that same edge, and the mismatching bit SHALL still be counted.
REQ-019 tap_q SHALL load tap every cycle; if tap != tap_q in any state other than reset, the FSM SHALL go to SEED with fill count 0.
REQ-020 locked, bit_err, err_cnt and state_out SHALL all be registered outputs.
REQ-021 bit_err SHALL be high in the cycle after the edge that sampled the erroneous bit.
REQ-022 locked SHALL rise in the cycle after the 16th valid bit of a clean stream, counted from SEED entry.
REQ-023 err_cnt SHALL saturate at all-ones.
REQ-024 clr_cnt takes precedence over a simultaneous increment; the result is 0.
REQ-025 err_cnt SHALL be retained across loss of lock.
REQ-026 din_valid low SHALL freeze sr, the fill/match counters and the FSM state; clr_cnt and the tap-change check still act.

Reset
REQ-027 Asserting reset SHALL asynchronously set state to SEED, sr = 8'h00, tap_q = 8'h00, all internal counters = 0, locked = 0, bit_err = 0, err_cnt = 0 and state_out = 8'h00.
REQ-028 Reset asserted mid-lock SHALL drop locked immediately, without waiting for a clock edge.
REQ-029 The first edge after reset release SHALL load tap_q without triggering a tap-change resync.

Structure
REQ-030 A shared package prbs_pkg SHALL hold the state enum typedef (SEED/VERIFY/LOCKED), the LFSR width constant 8 and a parity helper function.
REQ-031 The flywheel predictor (sr, tap_q, p) SHALL be a sub-module named prbs_predictor; the FSM and counters stay in the top module.

Verification
REQ-032 Clean lock: generator seed 8'h01, tap 8'hB8, continuous valid -> locked rises one cycle after the 16th bit; err_cnt stays 0 for 1000 bits.
REQ-033 Single error: flip bit 100 of a locked stream -> exactly one bit_err pulse one cycle later; err_cnt = 1; locked stays high; sr keeps tracking, with no further errors.
REQ-034 Loss of lock: force 4 consecutive flipped bits -> err_cnt = 4; locked falls on the 4th; relock 16 clean bits later.
REQ-035 Degenerate/verify failure: feed 8 zeros -> remains in SEED; inject a flip during VERIFY -> back to SEED; locked never asserts.
REQ-036 Boundaries: with CNT_W = 4, 20 errors -> err_cnt = 4'hF; clr_cnt together with an error -> err_cnt = 0; change tap 8'hB8 -> 8'h8E while locked -> locked falls next cycle.
REQ-037 Async reset and valid gaps: reset pulse between clock edges while locked -> all outputs 0 before the next edge; random din_valid gaps on a clean stream -> no bit_err.

Source files
------------

// File: rtl/prbs_pkg.sv
// Shared definitions for the PRBS checker: LFSR width, checker FSM states
// and the parity helper used by the flywheel predictor.
package prbs_pkg;

    localparam int LFSR_W = 8;

    typedef enum logic [1:0] {
        SEED   = 2'd0,
        VERIFY = 2'd1,
        LOCKED = 2'd2
    } chk_state_e;

    function automatic logic parity8(input logic [LFSR_W-1:0] v);
        return ^v;
    endfunction

endpackage

// File: rtl/prbs_predictor.sv
// Flywheel predictor: checker shift register, registered polynomial mask and
// the predicted next bit p = parity(sr & tap_q).
module prbs_predictor
    import prbs_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic [LFSR_W-1:0] tap,
    input  logic              shift_en,
    input  logic              shift_bit,
    output logic [LFSR_W-1:0] sr,
    output logic [LFSR_W-1:0] tap_reg,
    output logic              pred
);

    logic [LFSR_W-1:0] sr_q;
    logic [LFSR_W-1:0] sr_d;
    logic [LFSR_W-1:0] tap_q;
    logic [LFSR_W-1:0] tap_d;

    always_comb begin
        tap_d = tap;
        sr_d  = sr_q;
        if (shift_en) begin
            sr_d = {sr_q[LFSR_W-2:0], shift_bit};
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sr_q  <= '0;
            tap_q <= '0;
        end else begin
            sr_q  <= sr_d;
            tap_q <= tap_d;
        end
    end

    assign sr      = sr_q;
    assign tap_reg = tap_q;
    assign pred    = parity8(sr_q & tap_q);

endmodule

// File: rtl/prbs_checker_8bit.sv
// 8-bit PRBS checker: seeds from the received stream, verifies 8 predicted
// bits, then flywheels on its own prediction and counts bit errors.
module prbs_checker_8bit
    import prbs_pkg::*;
#(
    parameter int LOSS_THRESH = 4,
    parameter int CNT_W       = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [LFSR_W-1:0] tap,
    input  logic              din_valid,
    input  logic              din,
    input  logic              clr_cnt,
    output logic              locked,
    output logic              bit_err,
    output logic [CNT_W-1:0]  err_cnt,
    output logic [LFSR_W-1:0] state_out
);

    localparam logic [3:0] LAST_IDX = 4'(LFSR_W - 1);
    localparam logic [3:0] LOSS_LIM = 4'(LOSS_THRESH);

    chk_state_e        state_q;
    chk_state_e        state_d;
    logic [3:0]        fill_q;
    logic [3:0]        fill_d;
    logic [3:0]        match_q;
    logic [3:0]        match_d;
    logic [3:0]        consec_q;
    logic [3:0]        consec_d;
    logic              tap_vld_q;
    logic              tap_vld_d;
    logic              locked_q;
    logic              locked_d;
    logic              bit_err_q;
    logic              bit_err_d;
    logic [CNT_W-1:0]  err_cnt_q;
    logic [CNT_W-1:0]  err_cnt_d;

    logic              shift_en;
    logic              shift_bit;
    logic              pred;
    logic              mism;
    logic              tap_chg;
    logic              err_inc;
    logic [LFSR_W-1:0] sr;
    logic [LFSR_W-1:0] tap_reg;
    logic [LFSR_W-1:0] sr_next;

    prbs_predictor u_pred (
        .clk      (clk),
        .reset    (reset),
        .tap      (tap),
        .shift_en (shift_en),
        .shift_bit(shift_bit),
        .sr       (sr),
        .tap_reg  (tap_reg),
        .pred     (pred)
    );

    // tap_reg is only meaningful after the first post-reset edge has loaded it.
    assign tap_chg = tap_vld_q && (tap != tap_reg);
    assign mism    = din ^ pred;
    assign sr_next = {sr[LFSR_W-2:0], din};

    always_comb begin
        state_d   = state_q;
        fill_d    = fill_q;
        match_d   = match_q;
        consec_d  = consec_q;
        tap_vld_d = 1'b1;
        bit_err_d = 1'b0;
        err_inc   = 1'b0;
        shift_en  = 1'b0;
        shift_bit = din;

        if (tap_chg) begin
            state_d  = SEED;
            fill_d   = '0;
            match_d  = '0;
            consec_d = '0;
        end else if (din_valid) begin
            case (state_q)
                SEED: begin
                    shift_en = 1'b1;
                    if (fill_q == LAST_IDX) begin
                        fill_d = '0;
                        // An all-zero seed is the LFSR lock-up state; keep filling.
                        if (sr_next != '0) begin
                            state_d = VERIFY;
                            match_d = '0;
                        end
                    end else begin
                        fill_d = fill_q + 4'd1;
                    end
                end
                VERIFY: begin
                    shift_en = 1'b1;
                    if (mism) begin
                        state_d = SEED;
                        fill_d  = '0;
                    end else if (match_q == LAST_IDX) begin
                        state_d  = LOCKED;
                        match_d  = '0;
                        consec_d = '0;
                    end else begin
                        match_d = match_q + 4'd1;
                    end
                end
                LOCKED: begin
                    // Flywheel: the register follows its own prediction, not din.
                    shift_en  = 1'b1;
                    shift_bit = pred;
                    if (mism) begin
                        bit_err_d = 1'b1;
                        err_inc   = 1'b1;
                        if (consec_q >= LOSS_LIM - 4'd1) begin
                            state_d  = SEED;
                            fill_d   = '0;
                            consec_d = '0;
                        end else begin
                            consec_d = consec_q + 4'd1;
                        end
                    end else begin
                        consec_d = '0;
                    end
                end
                default: begin
                    state_d = SEED;
                    fill_d  = '0;
                end
            endcase
        end

        err_cnt_d = err_cnt_q;
        if (clr_cnt) begin
            err_cnt_d = '0;
        end else if (err_inc && (err_cnt_q != '1)) begin
            err_cnt_d = err_cnt_q + CNT_W'(1);
        end

        locked_d = (state_d == LOCKED);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= SEED;
            fill_q    <= '0;
            match_q   <= '0;
            consec_q  <= '0;
            tap_vld_q <= 1'b0;
            locked_q  <= 1'b0;
            bit_err_q <= 1'b0;
            err_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            fill_q    <= fill_d;
            match_q   <= match_d;
            consec_q  <= consec_d;
            tap_vld_q <= tap_vld_d;
            locked_q  <= locked_d;
            bit_err_q <= bit_err_d;
            err_cnt_q <= err_cnt_d;
        end
    end

    assign locked    = locked_q;
    assign bit_err   = bit_err_q;
    assign err_cnt   = err_cnt_q;
    assign state_out = sr;

endmodule

// File: tb/tb_prbs_checker_8bit.sv
// Directed bench for prbs_checker_8bit: lock, single error, loss of lock,
// degenerate seed, counter boundaries, tap change, async reset and valid gaps.
module tb_prbs_checker_8bit;

    logic        clk = 1'b0;
    logic        reset;
    logic [7:0]  tap;
    logic        din_valid;
    logic        din;
    logic        clr_cnt;
    logic        locked;
    logic        bit_err;
    logic [15:0] err_cnt;
    logic [7:0]  state_out;
    logic        locked4;
    logic        bit_err4;
    logic [3:0]  err_cnt4;
    logic [7:0]  state_out4;

    int          n_tests = 0;
    int          n_fail  = 0;
    int          err_seen;
    logic [7:0]  g;
    logic [7:0]  gtap;

    always #5 clk = ~clk;

    prbs_checker_8bit #(.LOSS_THRESH(4), .CNT_W(16)) dut (
        .clk(clk), .reset(reset), .tap(tap), .din_valid(din_valid), .din(din),
        .clr_cnt(clr_cnt), .locked(locked), .bit_err(bit_err),
        .err_cnt(err_cnt), .state_out(state_out)
    );

    prbs_checker_8bit #(.LOSS_THRESH(4), .CNT_W(4)) dut4 (
        .clk(clk), .reset(reset), .tap(tap), .din_valid(din_valid), .din(din),
        .clr_cnt(clr_cnt), .locked(locked4), .bit_err(bit_err4),
        .err_cnt(err_cnt4), .state_out(state_out4)
    );

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    // One clock with the reference generator; flip inverts the transmitted bit.
    task automatic step(input logic flip, input logic vld);
        logic b;
        b = ^(g & gtap);
        din_valid = vld;
        if (vld) begin
            din = b ^ flip;
            g   = {g[6:0], b};
        end else begin
            din = 1'($urandom_range(0, 1));
        end
        @(posedge clk);
        #1;
        if (bit_err) err_seen++;
    endtask

    task automatic step_raw(input logic bitv);
        din_valid = 1'b1;
        din       = bitv;
        @(posedge clk);
        #1;
        if (bit_err) err_seen++;
    endtask

    task automatic run_clean(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int nvalid;
        reset = 1'b1; tap = 8'hB8; gtap = 8'hB8;
        din_valid = 1'b0; din = 1'b0; clr_cnt = 1'b0; err_seen = 0;
        #2;
        check_val("rst_locked", 32'(locked), 32'h0);
        check_val("rst_bit_err", 32'(bit_err), 32'h0);
        check_val("rst_err_cnt", 32'(err_cnt), 32'h0);
        check_val("rst_state_out", 32'(state_out), 32'h0);
        #10 reset = 1'b0;

        // Clean lock from seed 01
        g = 8'h01;
        run_clean(8);
        check_val("fill_sr", 32'(state_out), 32'(g));
        run_clean(7);
        check_val("lock_15", 32'(locked), 32'h0);
        run_clean(1);
        check_val("lock_16", 32'(locked), 32'h1);
        err_seen = 0;
        run_clean(1000);
        check_val("clean_no_err", 32'(err_seen), 32'h0);
        check_val("clean_err_cnt", 32'(err_cnt), 32'h0);
        check_val("clean_locked", 32'(locked), 32'h1);
        check_val("clean_track", 32'(state_out), 32'(g));

        // Single error
        run_clean(99);
        step(1'b1, 1'b1);
        check_val("single_pulse", 32'(bit_err), 32'h1);
        check_val("single_cnt", 32'(err_cnt), 32'h1);
        check_val("single_locked", 32'(locked), 32'h1);
        step(1'b0, 1'b1);
        check_val("single_pulse_end", 32'(bit_err), 32'h0);
        err_seen = 0;
        run_clean(50);
        check_val("single_no_more", 32'(err_seen), 32'h0);
        check_val("single_cnt_hold", 32'(err_cnt), 32'h1);
        check_val("single_track", 32'(state_out), 32'(g));

        // Loss of lock after 4 consecutive errors
        clr_cnt = 1'b1; step(1'b0, 1'b0); clr_cnt = 1'b0;
        check_val("clr_idle", 32'(err_cnt), 32'h0);
        for (int i = 0; i < 3; i++) step(1'b1, 1'b1);
        check_val("loss_3_locked", 32'(locked), 32'h1);
        step(1'b1, 1'b1);
        check_val("loss_4_locked", 32'(locked), 32'h0);
        check_val("loss_4_cnt", 32'(err_cnt), 32'h4);
        run_clean(15);
        check_val("relock_15", 32'(locked), 32'h0);
        run_clean(1);
        check_val("relock_16", 32'(locked), 32'h1);
        check_val("relock_cnt_kept", 32'(err_cnt), 32'h4);

        // Counter saturation and clear precedence
        clr_cnt = 1'b1; step(1'b0, 1'b0); clr_cnt = 1'b0;
        for (int i = 0; i < 20; i++) begin
            step(1'b1, 1'b1);
            step(1'b0, 1'b1);
        end
        check_val("cnt20_wide", 32'(err_cnt), 32'd20);
        check_val("cnt20_sat4", 32'(err_cnt4), 32'hF);
        check_val("cnt20_locked", 32'(locked), 32'h1);
        clr_cnt = 1'b1; step(1'b1, 1'b1); clr_cnt = 1'b0;
        check_val("clr_vs_inc", 32'(err_cnt), 32'h0);
        check_val("clr_vs_inc_pulse", 32'(bit_err), 32'h1);

        // Tap change while locked
        step(1'b0, 1'b1);
        check_val("pre_tap_locked", 32'(locked), 32'h1);
        tap = 8'h8E;
        step(1'b0, 1'b1);
        check_val("tap_chg_unlock", 32'(locked), 32'h0);
        tap = 8'hB8;

        // Degenerate all-zero seed, then a VERIFY failure
        reset = 1'b1; #3; reset = 1'b0;
        err_seen = 0;
        for (int i = 0; i < 16; i++) step_raw(1'b0);
        check_val("zero_seed_unlocked", 32'(locked), 32'h0);
        check_val("zero_seed_sr", 32'(state_out), 32'h0);
        g = 8'h01;
        run_clean(11);
        step(1'b1, 1'b1);
        run_clean(4);
        check_val("verify_fail_16", 32'(locked), 32'h0);
        run_clean(11);
        check_val("verify_fail_27", 32'(locked), 32'h0);
        run_clean(1);
        check_val("verify_fail_28", 32'(locked), 32'h1);
        check_val("verify_no_err", 32'(err_seen), 32'h0);

        // Asynchronous reset between edges while locked
        step(1'b1, 1'b1);
        check_val("pre_rst_cnt", 32'(err_cnt), 32'h1);
        #3 reset = 1'b1;
        #1;
        check_val("arst_locked", 32'(locked), 32'h0);
        check_val("arst_bit_err", 32'(bit_err), 32'h0);
        check_val("arst_err_cnt", 32'(err_cnt), 32'h0);
        check_val("arst_state_out", 32'(state_out), 32'h0);
        #2 reset = 1'b0;

        // Clean stream with random valid gaps
        g = 8'h01;
        err_seen = 0;
        nvalid = 0;
        while (nvalid < 200) begin
            if ($urandom_range(0, 3) != 0) begin
                step(1'b0, 1'b1);
                nvalid++;
            end else begin
                step(1'b0, 1'b0);
            end
        end
        check_val("gap_no_err", 32'(err_seen), 32'h0);
        check_val("gap_locked", 32'(locked), 32'h1);
        check_val("gap_track", 32'(state_out), 32'(g));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
